// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback, stalls on mem_ready and counts retirements.
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOP,
    output logic [1:0]  PCSource,
    output logic        pc_en,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;

    // Next-state, sticky illegal flag and retire counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // lw/sw choice is captured here so MEMADR never looks at opcode again.
                case (opcode)
                    OP_LW:    begin state_d = S_MEMADR; is_store_d = 1'b0; end
                    OP_SW:    begin state_d = S_MEMADR; is_store_d = 1'b1; end
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    // Raw Moore decode; during reset muxes show FETCH values and strobes are masked.
    state_t out_state;
    logic   pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

    always_comb begin
        out_state     = rst ? S_FETCH : state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOP         = 3'b000;
        PCSource      = 2'b00;
        case (out_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = 3'b010;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOP         = 3'b001;
                pc_write_cond = 1'b1;
                PCSource      = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign PCWrite       = pc_write & ~rst;
    assign PCWriteCond   = pc_write_cond & ~rst;
    assign MemRead       = mem_read & ~rst;
    assign MemWrite      = mem_write & ~rst;
    assign IRWrite       = ir_write & ~rst;
    assign RegWrite      = reg_write & ~rst;
    assign pc_en         = PCWrite | (PCWriteCond & zero);
    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle state, control vector and
// retire count against hand-written instruction sequences.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOP;
    logic [1:0]  PCSource;
    logic        pc_en;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] instr_retired;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       pcen;
    } ctrl_t;

    ctrl_t dut_ctrl;
    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP,
                       PCSource, pc_en};

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
        .PCSource(PCSource), .pc_en(pc_en), .state(state),
        .illegal_op(illegal_op), .instr_retired(instr_retired)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Control vector each state must drive, written straight from the state table.
    function automatic ctrl_t exp_ctrl(input int s, input logic mr, input logic z, input logic r);
        ctrl_t c;
        c = '0;
        if (r) begin
            c.asb = 2'b01;
            return c;
        end
        case (s)
            0:  begin c.mrd = 1'b1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
            1:  c.asb = 2'b11;
            2:  begin c.asa = 1'b1; c.asb = 2'b10; end
            3:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            5:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            6:  begin c.asa = 1'b1; c.aop = 3'b010; end
            7:  begin c.rw = 1'b1; c.rdst = 1'b1; end
            8:  begin c.asa = 1'b1; c.aop = 3'b001; c.pcwc = 1'b1; c.psrc = 2'b01; end
            9:  begin c.asa = 1'b1; c.asb = 2'b10; end
            10: c.rw = 1'b1;
            11: begin c.pcw = 1'b1; c.psrc = 2'b10; end
            default: ;
        endcase
        c.pcen = c.pcw | (c.pcwc & z);
        return c;
    endfunction

    // Drives one instruction cycle by cycle; opcode is scrambled after DECODE.
    task automatic run_seq(input string tag, input logic [5:0] op, input int n,
                           input int st[8], input int mr[8], input int rt[8],
                           input logic zv, input int end_st, input int end_rt);
        int irw;
        irw    = 0;
        zero   = zv;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            mem_ready = mr[i][0];
            if (i > 0 && st[i-1] == 1) opcode = ~op;
            #1;
            @(negedge clk);
            check($sformatf("%s[%0d].state", tag, i), 32'(state), 32'(st[i]));
            check($sformatf("%s[%0d].ctrl", tag, i), 32'(dut_ctrl),
                  32'(exp_ctrl(st[i], mr[i][0], zv, 1'b0)));
            check($sformatf("%s[%0d].retired", tag, i), 32'(instr_retired), 32'(rt[i]));
            if (IRWrite) irw++;
            @(posedge clk);
            #1;
        end
        check({tag, ".end_state"}, 32'(state), 32'(end_st));
        check({tag, ".end_retired"}, 32'(instr_retired), 32'(end_rt));
        check({tag, ".irwrite_pulses"}, 32'(irw), 32'd1);
    endtask

    int st[8], mr[8], rt[8];

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = OP_RTYPE;

        // Power-on reset: strobes masked even though mem_ready is high.
        @(negedge clk);
        check("por.ctrl", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0, 1'b1)));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("por.state", 32'(state), 32'd0);
        check("por.retired", 32'(instr_retired), 32'd0);
        check("por.illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;

        st = '{0, 1, 6, 7, 0, 0, 0, 0}; mr = '{1, 1, 1, 1, 1, 1, 1, 1};
        rt = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("rtype", OP_RTYPE, 4, st, mr, rt, 1'b0, 0, 1);

        st = '{0, 0, 0, 1, 2, 3, 3, 4}; mr = '{0, 0, 1, 1, 1, 0, 1, 1};
        rt = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_seq("lw_wait", OP_LW, 8, st, mr, rt, 1'b0, 0, 2);

        st = '{0, 1, 2, 5, 5, 0, 0, 0}; mr = '{1, 1, 1, 0, 1, 1, 1, 1};
        rt = '{2, 2, 2, 2, 2, 0, 0, 0};
        run_seq("sw_wait", OP_SW, 5, st, mr, rt, 1'b0, 0, 3);

        st = '{0, 1, 8, 0, 0, 0, 0, 0}; mr = '{1, 1, 1, 1, 1, 1, 1, 1};
        rt = '{3, 3, 3, 0, 0, 0, 0, 0};
        run_seq("beq_taken", OP_BEQ, 3, st, mr, rt, 1'b1, 0, 4);
        rt = '{4, 4, 4, 0, 0, 0, 0, 0};
        run_seq("beq_not_taken", OP_BEQ, 3, st, mr, rt, 1'b0, 0, 5);

        st = '{0, 1, 0, 0, 0, 0, 0, 0};
        rt = '{5, 5, 0, 0, 0, 0, 0, 0};
        run_seq("illegal", 6'b111111, 2, st, mr, rt, 1'b0, 0, 5);
        check("illegal.flag", 32'(illegal_op), 32'd1);

        st = '{0, 1, 9, 10, 0, 0, 0, 0};
        rt = '{5, 5, 5, 5, 0, 0, 0, 0};
        run_seq("addi", OP_ADDI, 4, st, mr, rt, 1'b0, 0, 6);
        check("addi.illegal_sticky", 32'(illegal_op), 32'd1);

        st = '{0, 1, 11, 0, 0, 0, 0, 0};
        rt = '{6, 6, 6, 0, 0, 0, 0, 0};
        run_seq("jump", OP_J, 3, st, mr, rt, 1'b0, 0, 7);

        // lw stalled in MEMRD, then reset for two cycles aborts it.
        st = '{0, 1, 2, 3, 0, 0, 0, 0}; mr = '{1, 1, 1, 0, 1, 1, 1, 1};
        rt = '{7, 7, 7, 7, 0, 0, 0, 0};
        run_seq("lw_pre_rst", OP_LW, 4, st, mr, rt, 1'b0, 3, 7);
        rst = 1'b1;
        #1;
        @(negedge clk);
        check("mid_rst.state_before_edge", 32'(state), 32'd3);
        check("mid_rst.ctrl0", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        check("mid_rst.state", 32'(state), 32'd0);
        check("mid_rst.retired", 32'(instr_retired), 32'd0);
        check("mid_rst.illegal", 32'(illegal_op), 32'd0);
        mem_ready = 1'b1;
        #1;
        @(negedge clk);
        check("mid_rst.ctrl1", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0, 1'b1)));
        @(posedge clk); #1;
        check("mid_rst.state2", 32'(state), 32'd0);
        rst = 1'b0;

        st = '{0, 1, 11, 0, 0, 0, 0, 0}; mr = '{1, 1, 1, 1, 1, 1, 1, 1};
        rt = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("post_rst_j", OP_J, 3, st, mr, rt, 1'b0, 0, 1);

        // Preload the counter to its maximum; the next jump must wrap it.
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        rt = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 0, 0, 0, 0, 0};
        run_seq("wrap_j", OP_J, 3, st, mr, rt, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle MIPS control sequencer that replaces per-instruction combinational decode with a Moore state machine driving the shared datapath: PC, instruction/data memory port, IR, register file, and the single ALU. It steps each instruction through fetch, decode, execute, memory and writeback. It also stalls on a memory ready handshake and counts retired instructions. It sits beside the datapath top and consumes the IR opcode field and the ALU zero flag.

## Interface
- No parameters; state and counter widths are fixed.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOP  out  3  000 add, 001 sub, 010 funct-decoded (R-type)
- PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- pc_en  out  1  PCWrite | (PCWriteCond & zero)
- state  out  4  current state encoding, for debug
- illegal_op  out  1  sticky flag: unsupported opcode decoded
- instr_retired  out  16  retired-instruction counter

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and go to FETCH with all strobes 0.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOP=000.
  - Next state: lw/sw go to MEMADR; R-type to EXEC; beq to BRANCH; addi to ADDIEX; j to JUMP.
  - Any other opcode goes to FETCH and sets illegal_op.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=010. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCWriteCond=1, PCSource=01. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=000. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- instr_retired increments by 1 on the final cycle of each completed instruction:
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP count unconditionally.
  - MEMWR counts only in the cycle mem_ready=1.
  - Illegal opcodes do not count.
  - The counter wraps 0xFFFF to 0x0000.
- illegal_op is cleared only by rst.

## Timing
- Outputs are combinational from the registered state; only the FETCH strobes IRWrite and PCWrite, and pc_en, also depend on inputs (mem_ready, zero).
- Cycle counts with zero-wait memory (mem_ready tied high): R-type 4, lw 5, sw 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset:
  - While rst=1, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, pc_en) are forced to 0.
  - On the clock edge with rst=1: state becomes FETCH (0), instr_retired becomes 0, illegal_op becomes 0.
  - Mux selects show their FETCH values during reset.
- rst asserted mid-instruction (including during a memory wait) aborts it with no retire count. The first cycle after rst deasserts is FETCH.
- opcode is sampled only in DECODE; changes in other states are ignored.

## Test plan
- Reset: hold rst for 2 cycles in the middle of lw at MEMRD -> state=0, instr_retired=0, illegal_op=0, all strobes 0 during reset; FETCH on the first cycle after release.
- R-type, mem_ready=1: state sequence 0,1,6,7,0; ALUOP=010 in EXEC; RegWrite=1 and RegDst=1 only in ALUWB; instr_retired goes 0 -> 1.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD: 8 total cycles; IRWrite pulses exactly once; MemtoReg=1 in MEMWB.
- beq with zero=1, then with zero=0: sequence 0,1,8,0 both times; pc_en=1 in BRANCH only when zero=1; instr_retired +1 each time.
- Illegal opcode 111111: DECODE goes to FETCH; illegal_op=1 and stays 1 through a following addi (0,1,9,10,0); count increments only for the addi.
- Counter wrap: preload to 0xFFFF via 65535 j instructions (or force) -> the next j gives instr_retired=0x0000.
